// File: rtl/shared_q_arbiter.sv
// shared_q_arbiter
// Round-robin arbiter that hands a single shared net (n3) to one of two
// requesters at a time. Every hand-over passes through a one-cycle dead
// state (RELEASE) so that the net never has two drivers.
//
// Optional feature: define SHARED_Q_ARBITER_HOLD_TIMEOUT_EN to build a hold
// watchdog. It forces a release after HOLD_MAX grant cycles and pulses
// timeout during that release. When the macro is not defined, HOLD_MAX is
// unused, timeout is tied low and a grant is held until the owner gives it up.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - synchronous active-high reset
//   req     - req[i]: requester i wants the shared net
//   done    - done[i]: requester i releases the net (honoured from the owner only)
//   q_in    - q_in[i]: Q output of requester i
//   gnt     - registered one-hot grant, 2'b00 when there is no owner
//   n3      - shared net, q_in[owner] while granted, else 0
//   busy    - high in GRANT and RELEASE
//   timeout - one-cycle pulse on a forced release
module shared_q_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic [1:0] q_in,
  output logic [1:0] gnt,
  output logic       n3,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       owner, owner_nx;
  logic       last, last_nx;
  logic [1:0] gnt_nx;
  logic       release_now;
  logic       hold_expired;

  // On a tie the requester that was not served last wins.
  function automatic logic pick(input logic [1:0] r, input logic l);
    if (r == 2'b11) return ~l;
    return r[1];
  endfunction

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    gnt_nx      = gnt;
    release_now = done[owner] | ~req[owner];
    case (state)
      IDLE, RELEASE: begin
        if (|req) begin
          state_nx = GRANT;
          owner_nx = pick(req, last);
          last_nx  = owner_nx;
          gnt_nx   = owner_nx ? 2'b10 : 2'b01;
        end else begin
          state_nx = IDLE;
          gnt_nx   = 2'b00;
        end
      end
      GRANT: begin
        if (release_now || hold_expired) begin
          state_nx = RELEASE;
          gnt_nx   = 2'b00;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

`ifdef SHARED_Q_ARBITER_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_r;

  // hold_cnt counts completed GRANT cycles of the current owner; on the
  // HOLD_MAX-th grant cycle it reads HOLD_MAX-1.
  assign hold_expired = (state == GRANT) && (hold_cnt == 8'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      if (state_nx == GRANT && state != GRANT) hold_cnt <= 8'd0;
      else if (state == GRANT)                 hold_cnt <= hold_cnt + 8'd1;
      // A genuine release in the expiry cycle is not a timeout.
      timeout_r <= (state == GRANT) && hold_expired && !release_now;
    end
  end

  assign timeout = timeout_r;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign n3   = |(gnt & q_in);

endmodule

// File: tb/tb_shared_q_arbiter.sv
module tb_shared_q_arbiter;

  localparam int HM = 4;
`ifdef SHARED_Q_ARBITER_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, done, q_in;
  logic [1:0] gnt;
  logic       n3, busy, timeout;

  shared_q_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .q_in(q_in),
    .gnt(gnt), .n3(n3), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    logic       busy;
    logic       tout;
    logic       n3;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: who holds the net, whether we are in the dead cycle,
  // who was served last, and how many grant cycles the holder has used.
  int holder = -1;
  bit dead   = 1'b0;
  int last_w = 1;
  int used   = 0;

  function automatic int winner(input logic [1:0] r, input int l);
    if (r == 2'b11) return 1 - l;
    return r[1] ? 1 : 0;
  endfunction

  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] dn);
    exp_t e;
    bit   tout;
    logic [1:0] qv;
    @(negedge clk);
    qv   = 2'($urandom_range(0, 3));
    rst  = r;
    req  = rq;
    done = dn;
    q_in = qv;
    tout = 1'b0;
    if (r) begin
      holder = -1; dead = 1'b0; last_w = 1; used = 0;
    end else if (dead || holder < 0) begin
      dead = 1'b0;
      if (rq != 2'b00) begin
        holder = winner(rq, last_w);
        last_w = holder;
        used   = 0;
      end else begin
        holder = -1;
      end
    end else begin
      bit normal, expired;
      used    = used + 1;
      normal  = dn[holder] || !rq[holder];
      expired = TO_EN && (used >= HM);
      if (normal || expired) begin
        tout   = expired && !normal;
        holder = -1;
        dead   = 1'b1;
      end
    end
    e.gnt  = (holder >= 0) ? ((holder == 1) ? 2'b10 : 2'b01) : 2'b00;
    e.busy = (holder >= 0) || dead;
    e.tout = tout;
    e.n3   = |(e.gnt & qv);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Monitor: every clock edge the DUT presents a new set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",     gnt,           e.gnt);
        chk("busy",    {1'b0, busy},    {1'b0, e.busy});
        chk("timeout", {1'b0, timeout}, {1'b0, e.tout});
        chk("n3",      {1'b0, n3},      {1'b0, e.n3});
      end
    end
  end

  initial begin
    logic [1:0] rq;
    rst = 1'b1; req = 2'b00; done = 2'b00; q_in = 2'b00;
    // Reset, then a tie goes to requester 0; q_in toggles ride along.
    step(1, 2'b11, 2'b00);
    step(1, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 2'b11, 2'b00);
    // Owner 0 releases, then owner 1 releases: alternation through dead cycles.
    step(0, 2'b11, 2'b01);
    for (int i = 0; i < 2; i++) step(0, 2'b11, 2'b00);
    // Non-owner noise while requester 1 holds the net.
    step(0, 2'b10, 2'b01);
    step(0, 2'b10, 2'b00);
    step(0, 2'b11, 2'b10);
    for (int i = 0; i < 2; i++) step(0, 2'b11, 2'b00);
    // Reset in the middle of a grant, then a fresh tie.
    step(1, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 2'b11, 2'b00);
    // Drop and re-assert during the dead cycle.
    step(0, 2'b00, 2'b00);
    step(0, 2'b11, 2'b00);
    step(0, 2'b11, 2'b00);
    // Randomized traffic with sticky requests and occasional resets.
    rq = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), rq,
           {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
    end
    // Long single-requester hold with no done.
    step(1, 2'b00, 2'b00);
    for (int i = 0; i < 300; i++) step(0, 2'b01, 2'b00);
    @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
